port_arbiter: RTL

PORT_ARBITER -- requirements
Module: port_arbiter

---
 rtl/port_arbiter_pkg.sv | 20 ++
 rtl/port_arbiter_if.sv | 29 ++
 rtl/port_arbiter_rr_arbiter.sv | 33 +++
 rtl/port_arbiter.sv | 78 +++++++
 4 files changed

// File: rtl/port_arbiter_pkg.sv
// Shared NoC router constants: port count, packet width and router port indices.
package pa_noc;

  localparam int N_PORTS      = 5;
  localparam int PACKET_WIDTH = 16;

  typedef enum logic [2:0] {
    NI    = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } port_e;

  // Index width that stays legal for a single-port configuration.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/port_arbiter_if.sv
// Request/accept bundle between the input ports and one router output port.
interface port_arbiter_if
  import pa_noc::*;
#(
  parameter int N_PORTS      = pa_noc::N_PORTS,
  parameter int PACKET_WIDTH = pa_noc::PACKET_WIDTH
);
  localparam int IDX_W = idxWidth(N_PORTS);

  logic [N_PORTS-1:0]              i_valid;
  logic [N_PORTS*PACKET_WIDTH-1:0] i_packet;
  logic [N_PORTS-1:0]              o_ready;
  logic [PACKET_WIDTH-1:0]         o_packet;
  logic                            o_valid;
  logic                            i_ready;
  logic [IDX_W-1:0]                o_grantIdx;

  // Traffic sources and the downstream consumer sit on the master side.
  modport master (
    output i_valid, i_packet, i_ready,
    input  o_ready, o_packet, o_valid, o_grantIdx
  );

  modport slave (
    input  i_valid, i_packet, i_ready,
    output o_ready, o_packet, o_valid, o_grantIdx
  );

endinterface

// File: rtl/port_arbiter_rr_arbiter.sv
// Combinational rotating-priority pick: first set request at or above ptr, wrapping.
module rr_arbiter
  import pa_noc::*;
#(
  parameter int N_PORTS = pa_noc::N_PORTS,
  parameter int IDX_W   = idxWidth(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_PORTS-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic found;
  int   k;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      k = int'(ptr) + i;
      if (k >= N_PORTS) k = k - N_PORTS;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/port_arbiter.sv
// One router output port: round-robin over the inputs into a single registered output slot.
module port_arbiter
  import pa_noc::*;
#(
  parameter int N_PORTS      = pa_noc::N_PORTS,
  parameter int PACKET_WIDTH = pa_noc::PACKET_WIDTH
) (
  input logic           i_clk,
  input logic           i_srst,
  port_arbiter_if.slave bus
);

  localparam int IDX_W = idxWidth(N_PORTS);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]              state_p1;
  logic [PACKET_WIDTH-1:0] packet_p1;
  logic [IDX_W-1:0]        grantIdx_p1;
  logic [IDX_W-1:0]        rrPtr;

  logic [N_PORTS-1:0]      grant;
  logic [IDX_W-1:0]        winIdx;
  logic [IDX_W-1:0]        nextPtr;
  logic [PACKET_WIDTH-1:0] winPacket;
  logic                    slotFree;
  logic                    inXfer;
  logic                    outXfer;

  rr_arbiter #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (bus.i_valid),
    .ptr   (rrPtr),
    .grant (grant),
    .idx   (winIdx)
  );

  // Slot can take a packet when empty or when its occupant leaves this same edge.
  assign slotFree    = (state_p1 == EMPTY) || bus.i_ready;
  assign bus.o_ready = (slotFree && !i_srst) ? grant : '0;
  assign inXfer      = |bus.o_ready;
  assign outXfer     = (state_p1 == FULL) && bus.i_ready;
  assign nextPtr     = (winIdx == IDX_W'(N_PORTS - 1)) ? '0 : winIdx + 1'b1;

  always_comb begin
    winPacket = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (grant[k]) winPacket = bus.i_packet[k*PACKET_WIDTH +: PACKET_WIDTH];
    end
  end

  // ---- stage p1: registered output slot ----
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_p1    <= EMPTY;
      packet_p1   <= '0;
      grantIdx_p1 <= '0;
      rrPtr       <= '0;
    end else if (inXfer) begin
      state_p1    <= FULL;
      packet_p1   <= winPacket;
      grantIdx_p1 <= winIdx;
      rrPtr       <= nextPtr;
    end else if (outXfer) begin
      state_p1    <= EMPTY;
      packet_p1   <= '0;
      grantIdx_p1 <= '0;
    end
  end

  assign bus.o_valid    = state_p1;
  assign bus.o_packet   = packet_p1;
  assign bus.o_grantIdx = grantIdx_p1;

endmodule
